aes_round: RTL and testbench
============================

# aes_round

Single-round datapath of the AES-128 encryption pipeline. One instance takes the current 128-bit state and the previous round key, and performs one cipher round. It derives the next round key on the fly and registers both results. Nine instances with FINAL=0 form rounds 1–9 and one instance with FINAL=1 forms round 10. The top level supplies plaintext XOR cipher key as the round-1 state.

## Interface
Parameters:
- FINAL, default 0: 0 = normal round (SubBytes, ShiftRows, MixColumns, AddRoundKey); 1 = final round (MixColumns omitted).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- rc  input  4  round-constant index, 0..9, selects Rcon (equal to round number minus 1).
- inputdata  input  128  state entering the round.
- inkey  input  128  previous round key (cipher key for round 1).
- outkey  output  128  next round key, registered.
- r_out  output  128  round result state, registered.

## Operation
- Byte order: bits [127:120] = byte 0. State s[r][c] = byte 4c+r (FIPS-197 column-major). Key words w0..w3 = inkey[127:96], [95:64], [63:32], [31:0].
- Rcon by rc: 0→01, 1→02, 2→04, 3→08, 4→10, 5→20, 6→40, 7→80, 8→1b, 9→36. rc 10..15 → 00.
- Key expansion:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - nextkey = {n0,n1,n2,n3}
- SubBytes: standard AES S-box on all 16 bytes. The key path uses 4 further S-box copies. The S-box may be a 256-entry lookup or a GF(2^8) inverse plus affine transform; the results must be identical.
- ShiftRows: row r rotates left by r columns.
- MixColumns (FINAL=0 only): per column, multiply by matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8), reduction polynomial 0x11b (xtime: shift left, then XOR 0x1b if bit 7 was set).
- AddRoundKey uses nextkey, not inkey:
  - FINAL=0: r_out = MixColumns(ShiftRows(SubBytes(inputdata))) ^ nextkey
  - FINAL=1: r_out = ShiftRows(SubBytes(inputdata)) ^ nextkey
- outkey = nextkey in both modes. The FINAL=1 outkey port may be left unconnected.
- No handshake. Every clock computes a new result; the block is fully pipelinable.

## Timing
- All combinational logic sits between the inputs and one output register stage. Latency is 1 cycle: the result for inputs sampled at edge k appears after edge k, with no bubbles.
- A 10-instance chain has 10 cycles of latency from round-1 input to ciphertext.
- While rst_n is low, r_out and outkey are 128'h0. Reset asserts immediately, without waiting for a clock.
- First capture happens on the first rising clk edge after rst_n deasserts.
- Reset asserted mid-stream discards the in-flight result; outputs return to 0 at once.
- Inputs need to be stable only in the setup window before the clock edge.
- Target: complete the round logic within one clock period.

## Test plan
All vectors are FIPS-197 Appendix B (key 2b7e151628aed2a6abf7158809cf4f3c).
- Reset: hold rst_n=0 with arbitrary inputs and toggle clk → r_out=0, outkey=0. Assert rst_n between edges while outputs are nonzero → both outputs go to 0 without a clock edge.
- Round 1 (FINAL=0): rc=0, inkey=2b7e151628aed2a6abf7158809cf4f3c, inputdata=193de3bea0f4e22b9ac68d2ae9f84808, one edge → outkey=a0fafe1788542cb123a339392a6c7605, r_out=a49c7ff2689f352b6b5bea43026a5049.
- Round 2 (FINAL=0): rc=1, inkey=a0fafe1788542cb123a339392a6c7605, inputdata=a49c7ff2689f352b6b5bea43026a5049 → outkey=f2c295f27a96b9435935807a7359f67f, r_out=aa8f5f0361dde3ef82d24ad26832469a.
- Final round (FINAL=1): rc=9, inkey=ac7766f319fadc2128d12941575c006e, inputdata=eb40f21e592e38848ba113e71bc342d2 → outkey=d014f9a8c9ee2589e13f0cc8b6630ca6, r_out=3925841d02dc09fbdc118597196a0b32.
- Full chain: 9 normal instances plus 1 final instance, with plaintext 3243f6a8885a308d313198a2e0370734 XOR key as the first state → ciphertext 3925841d02dc09fbdc118597196a0b32 exactly 10 cycles after input. Change the input on consecutive cycles → a new ciphertext each cycle.
- Out-of-range rc: rc=10..15 → key expansion uses Rcon=00. Check against a reference model with Rcon 00.

Source files
------------

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one AES-128 encryption round with on-the-fly key expansion, registered outputs
module aes_round #(
    parameter bit FINAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   rc,
    input  logic [127:0] inputdata,
    input  logic [127:0] inkey,
    output logic [127:0] outkey,
    output logic [127:0] r_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (zero maps to zero), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    logic [31:0]  rot_word;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    always_comb begin
        rot_word = {inkey[23:0], inkey[31:24]};
        t_word   = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])} ^ {rcon_of(rc), 24'h0};
        n0       = inkey[127:96] ^ t_word;
        n1       = inkey[95:64]  ^ n0;
        n2       = inkey[63:32]  ^ n1;
        n3       = inkey[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    logic [127:0] sb_state;
    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] round_state;

    // Byte k of the state sits at bits [127-8k -: 8]; s[r][c] is byte 4c+r.
    always_comb begin
        sb_state = '0;
        sr_state = '0;
        mc_state = '0;
        for (int i = 0; i < 16; i++)
            sb_state[127-8*i -: 8] = sbox(byte_at(inputdata, i));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr_state[127-8*(4*c+r) -: 8] = byte_at(sb_state, 4*((c+r)%4)+r);
        for (int c = 0; c < 4; c++) begin
            mc_state[127-8*(4*c)   -: 8] = xtime(byte_at(sr_state, 4*c)) ^ xtime(byte_at(sr_state, 4*c+1))
                                         ^ byte_at(sr_state, 4*c+1) ^ byte_at(sr_state, 4*c+2)
                                         ^ byte_at(sr_state, 4*c+3);
            mc_state[127-8*(4*c+1) -: 8] = byte_at(sr_state, 4*c) ^ xtime(byte_at(sr_state, 4*c+1))
                                         ^ xtime(byte_at(sr_state, 4*c+2)) ^ byte_at(sr_state, 4*c+2)
                                         ^ byte_at(sr_state, 4*c+3);
            mc_state[127-8*(4*c+2) -: 8] = byte_at(sr_state, 4*c) ^ byte_at(sr_state, 4*c+1)
                                         ^ xtime(byte_at(sr_state, 4*c+2)) ^ xtime(byte_at(sr_state, 4*c+3))
                                         ^ byte_at(sr_state, 4*c+3);
            mc_state[127-8*(4*c+3) -: 8] = xtime(byte_at(sr_state, 4*c)) ^ byte_at(sr_state, 4*c)
                                         ^ byte_at(sr_state, 4*c+1) ^ byte_at(sr_state, 4*c+2)
                                         ^ xtime(byte_at(sr_state, 4*c+3));
        end
        round_state = (FINAL ? sr_state : mc_state) ^ next_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            outkey <= '0;
        end else begin
            r_out  <= round_state;
            outkey <= next_key;
        end
    end

endmodule

// File: tb/tb_aes_round.sv
// tb/tb_aes_round.sv - directed FIPS-197 vector bench for aes_round, single rounds and a 10-round chain
module tb_aes_round;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IN1_A  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1_A   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] K2_A   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R2_A   = 128'haa8f5f0361dde3ef82d24ad26832469a;
    localparam logic [127:0] K9_A   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] IN10_A = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] K10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT_A   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IN1_B  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] CT_B   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   r_rc;
    logic [127:0] r_data, r_key, r_okey, r_rout;
    logic [3:0]   f_rc;
    logic [127:0] f_data, f_key, f_okey, f_rout;
    logic [127:0] ch_state [11];
    logic [127:0] ch_key   [11];

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] rcon_tab [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    aes_round #(.FINAL(1'b0)) u_round (
        .clk(clk), .rst_n(rst_n), .rc(r_rc), .inputdata(r_data), .inkey(r_key),
        .outkey(r_okey), .r_out(r_rout)
    );

    aes_round #(.FINAL(1'b1)) u_final (
        .clk(clk), .rst_n(rst_n), .rc(f_rc), .inputdata(f_data), .inkey(f_key),
        .outkey(f_okey), .r_out(f_rout)
    );

    for (genvar g = 0; g < 10; g++) begin : g_chain
        aes_round #(.FINAL(g == 9)) u_stage (
            .clk(clk), .rst_n(rst_n), .rc(4'(g)), .inputdata(ch_state[g]), .inkey(ch_key[g]),
            .outkey(ch_key[g+1]), .r_out(ch_state[g+1])
        );
    end

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [127:0] delta;
        r_rc = 4'd0;  r_data = IN1_A;  r_key = KEY_A;
        f_rc = 4'd9;  f_data = IN10_A; f_key = K9_A;
        ch_state[0] = IN1_A; ch_key[0] = KEY_A;

        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_round_rout", r_rout, '0);
        check_vec("reset_round_okey", r_okey, '0);
        check_vec("reset_final_rout", f_rout, '0);
        check_vec("reset_final_okey", f_okey, '0);
        check_vec("reset_chain_out", ch_state[10], '0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_vec("round1_okey", r_okey, K1_A);
        check_vec("round1_rout", r_rout, R1_A);
        check_vec("final_okey", f_okey, K10_A);
        check_vec("final_rout", f_rout, CT_A);

        #2 rst_n = 1'b0;
        #1;
        check_vec("async_reset_rout", r_rout, '0);
        check_vec("async_reset_okey", r_okey, '0);
        check_vec("async_reset_final", f_rout, '0);
        #1 rst_n = 1'b1;

        r_rc = 4'd1; r_data = R1_A; r_key = K1_A;
        @(posedge clk);
        #1;
        check_vec("round2_okey", r_okey, K2_A);
        check_vec("round2_rout", r_rout, R2_A);

        // Changing only Rcon flips the top byte of every key word by the Rcon difference.
        r_data = IN1_A; r_key = KEY_A;
        for (int k = 0; k < 16; k++) begin
            r_rc = 4'(k);
            delta = {4{rcon_tab[k] ^ 8'h01, 24'h0}};
            @(posedge clk);
            #1;
            check_vec($sformatf("rc%0d_okey", k), r_okey, K1_A ^ delta);
            check_vec($sformatf("rc%0d_rout", k), r_rout, R1_A ^ delta);
        end

        ch_state[0] = IN1_A; ch_key[0] = KEY_A;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin ch_state[0] = IN1_B; ch_key[0] = KEY_B; end
            if (cyc == 2) begin ch_state[0] = IN1_A; ch_key[0] = KEY_A; end
            if (cyc == 10) check_vec("chain_ct_a", ch_state[10], CT_A);
            if (cyc == 11) check_vec("chain_ct_b", ch_state[10], CT_B);
            if (cyc == 12) check_vec("chain_ct_a_again", ch_state[10], CT_A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
